// File: rtl/branch_predict_ctrl_if.sv
// branch_predict_ctrl_if: ID prediction, EX resolution, redirect and statistics bundle
interface branch_predict_ctrl_if;
   logic        id_valid;
   logic        id_is_branch;
   logic [31:0] id_pc;
   logic [31:0] id_target;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        ex_branch_taken;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        pc_ready;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;
   modport master (
      output id_valid, id_is_branch, id_pc, id_target,
      output ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_target,
      output ex_branch_taken, ex_pred_taken, ex_pred_target, pc_ready,
      input  pred_taken, pred_target, flush_if_id, flush_id_ex,
      input  redirect_valid, redirect_pc, branch_count, mispredict_count
   );
   modport slave (
      input  id_valid, id_is_branch, id_pc, id_target,
      input  ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_target,
      input  ex_branch_taken, ex_pred_taken, ex_pred_target, pc_ready,
      output pred_taken, pred_target, flush_if_id, flush_id_ex,
      output redirect_valid, redirect_pc, branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit BHT prediction in ID, resolution and redirect in EX, statistics
module branch_predict_ctrl #(
   parameter int BHT_ENTRIES = 16,
   parameter int IDX_W       = 4
) (
   input logic clk,
   input logic reset_n,
   branch_predict_ctrl_if.slave bus
);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t           state, state_next;
   logic [1:0]       bht [BHT_ENTRIES];
   logic [31:0]      held_pc, correct_pc, bc, mc;
   logic             resolve, actual, mispredict, redirect_now, redirect;
   logic [IDX_W-1:0] id_idx, ex_idx;
   assign id_idx = bus.id_pc[IDX_W+1:2];
   assign ex_idx = bus.ex_pc[IDX_W+1:2];
   assign bus.branch_count     = bc;
   assign bus.mispredict_count = mc;
   // decode the EX resolution; wrong-path resolutions during HOLD are ignored
   always_comb begin
      resolve      = reset_n && state == IDLE && bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump);
      actual       = bus.ex_is_jump || bus.ex_branch_taken;
      mispredict   = (actual != bus.ex_pred_taken) ||
                     (actual && bus.ex_pred_taken && bus.ex_target != bus.ex_pred_target);
      correct_pc   = actual ? bus.ex_target : bus.ex_pc + 32'd4;
      redirect_now = resolve && mispredict;
   end
   // redirect FSM next state and outputs; flush overrides the ID prediction
   always_comb begin
      state_next          = state == HOLD ? (bus.pc_ready ? IDLE : HOLD)
                                          : (redirect_now && !bus.pc_ready ? HOLD : IDLE);
      redirect            = state == HOLD || redirect_now;
      bus.redirect_valid  = redirect;
      bus.redirect_pc     = state == HOLD ? held_pc : (redirect_now ? correct_pc : '0);
      bus.flush_if_id     = redirect;
      bus.flush_id_ex     = redirect;
      bus.pred_taken      = bus.id_valid && bus.id_is_branch && bht[id_idx][1] && !redirect;
      bus.pred_target     = bus.pred_taken ? bus.id_target : bus.id_pc + 32'd4;
   end
   // FSM state and the redirect address held while the PC unit stalls
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         held_pc <= '0;
      end else begin
         state <= state_next;
         if (redirect_now && !bus.pc_ready) held_pc <= correct_pc;
      end
   end
   // saturating counter update, conditional branches only
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else if (resolve && bus.ex_is_branch) begin
         bht[ex_idx] <= bus.ex_branch_taken ? (bht[ex_idx] == 2'b11 ? 2'b11 : bht[ex_idx] + 2'd1)
                                            : (bht[ex_idx] == 2'b00 ? 2'b00 : bht[ex_idx] - 2'd1);
      end
   end
   // saturating branch and mispredict statistics
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bc <= '0;
         mc <= '0;
      end else if (resolve) begin
         bc <= &bc ? bc : bc + 32'd1;
         if (mispredict) mc <= &mc ? mc : mc + 32'd1;
      end
   end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed scoreboard bench for branch_predict_ctrl
module tb_branch_predict_ctrl;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   typedef struct {
      string       name;
      logic        rv;
      logic [31:0] rpc;
      logic        pt;
      logic [31:0] ptg;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;
   exp_t q[$];
   exp_t e;
   branch_predict_ctrl_if b();
   branch_predict_ctrl #(.BHT_ENTRIES(16), .IDX_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(b));
   always #5 clk = ~clk;
   function automatic void cmp(string n, string f, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
      end
   endfunction
   // monitor: pops the expected response for the cycle and compares mid-cycle
   always @(negedge clk) begin
      if (q.size() != 0) begin
         e = q.pop_front();
         cmp(e.name, "redirect_valid", 32'(b.redirect_valid), 32'(e.rv));
         cmp(e.name, "redirect_pc", b.redirect_pc, e.rpc);
         cmp(e.name, "flush_if_id", 32'(b.flush_if_id), 32'(e.rv));
         cmp(e.name, "flush_id_ex", 32'(b.flush_id_ex), 32'(e.rv));
         cmp(e.name, "pred_taken", 32'(b.pred_taken), 32'(e.pt));
         cmp(e.name, "pred_target", b.pred_target, e.ptg);
         cmp(e.name, "branch_count", b.branch_count, e.bc);
         cmp(e.name, "mispredict_count", b.mispredict_count, e.mc);
      end
   end
   task automatic chk(string n, logic rv, logic [31:0] rpc, logic pt, logic [31:0] ptg,
                      logic [31:0] bc, logic [31:0] mc);
      exp_t x;
      x.name = n; x.rv = rv; x.rpc = rpc; x.pt = pt; x.ptg = ptg; x.bc = bc; x.mc = mc;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      b.id_valid = 0; b.id_is_branch = 0; b.id_pc = '0; b.id_target = '0;
      b.ex_valid = 0; b.ex_is_branch = 0; b.ex_is_jump = 0; b.ex_pc = '0; b.ex_target = '0;
      b.ex_branch_taken = 0; b.ex_pred_taken = 0; b.ex_pred_target = '0; b.pc_ready = 1;
   endtask
   task automatic id_br(logic [31:0] pc, logic [31:0] tgt);
      b.id_valid = 1; b.id_is_branch = 1; b.id_pc = pc; b.id_target = tgt;
   endtask
   task automatic ex(logic br, logic jp, logic [31:0] pc, logic [31:0] tgt, logic tk, logic ptk,
                     logic [31:0] ptg, logic rdy);
      b.ex_valid = 1; b.ex_is_branch = br; b.ex_is_jump = jp; b.ex_pc = pc; b.ex_target = tgt;
      b.ex_branch_taken = tk; b.ex_pred_taken = ptk; b.ex_pred_target = ptg; b.pc_ready = rdy;
   endtask
   initial begin
      reset_n = 0;
      idle();
      @(posedge clk);
      #1;
      chk("reset", 0, 0, 0, 32'h4, 0, 0);
      reset_n = 1;
      idle(); id_br(32'h40, 32'h80);
      chk("id_first", 0, 0, 0, 32'h44, 0, 0);
      idle(); ex(1, 0, 32'h40, 32'h80, 1, 0, 32'h44, 1);
      chk("mis_taken", 1, 32'h80, 0, 32'h4, 0, 0);
      idle(); id_br(32'h40, 32'h80);
      chk("pred_weak_t", 0, 0, 1, 32'h80, 1, 1);
      for (int i = 0; i < 3; i++) begin
         idle(); ex(1, 0, 32'h40, 32'h80, 1, 1, 32'h80, 1);
         chk("taken_ok", 0, 0, 0, 32'h4, 32'(1 + i), 1);
      end
      idle(); ex(1, 0, 32'h40, 32'h80, 0, 1, 32'h80, 1);
      chk("mis_nt", 1, 32'h44, 0, 32'h4, 4, 1);
      idle(); id_br(32'h40, 32'h80);
      chk("pred_after_sat", 0, 0, 1, 32'h80, 5, 2);
      idle(); id_br(32'h40, 32'h80); ex(1, 0, 32'h40, 32'h80, 0, 0, 32'h44, 1);
      chk("same_idx", 0, 0, 1, 32'h80, 5, 2);
      idle(); id_br(32'h40, 32'h80);
      chk("pred_dec", 0, 0, 0, 32'h44, 6, 2);
      idle(); ex(1, 0, 32'h104, 32'h200, 1, 0, 32'h108, 0);
      chk("hold0", 1, 32'h200, 0, 32'h4, 6, 2);
      idle(); id_br(32'h104, 32'h200); ex(1, 0, 32'h104, 32'h200, 1, 0, 32'h108, 0);
      chk("hold1", 1, 32'h200, 0, 32'h108, 7, 3);
      idle(); b.pc_ready = 0;
      chk("hold2", 1, 32'h200, 0, 32'h4, 7, 3);
      idle();
      chk("hold3", 1, 32'h200, 0, 32'h4, 7, 3);
      idle(); id_br(32'h104, 32'h200);
      chk("post_hold", 0, 0, 1, 32'h200, 7, 3);
      idle(); ex(0, 1, 32'h300, 32'h400, 0, 0, 32'h304, 1);
      chk("jal_nt", 1, 32'h400, 0, 32'h4, 7, 3);
      idle(); id_br(32'h40, 32'h80);
      chk("jal_no_bht", 0, 0, 0, 32'h44, 8, 4);
      idle(); ex(0, 1, 32'h300, 32'h400, 0, 1, 32'h400, 1);
      chk("jal_ok", 0, 0, 0, 32'h4, 8, 4);
      idle(); ex(0, 1, 32'h300, 32'h400, 0, 1, 32'h500, 1);
      chk("jal_bad_tgt", 1, 32'h400, 0, 32'h4, 9, 4);
      idle(); ex(1, 0, 32'hFFFF_FFFC, 32'h1000, 0, 1, 32'h1000, 0);
      chk("wrap", 1, 32'h0, 0, 32'h4, 10, 5);
      idle(); b.pc_ready = 0;
      chk("wrap_hold", 1, 32'h0, 0, 32'h4, 11, 6);
      idle(); b.pc_ready = 0; reset_n = 0;
      chk("reset_hold", 0, 0, 0, 32'h4, 0, 0);
      reset_n = 1;
      idle(); id_br(32'h104, 32'h200);
      chk("post_reset", 0, 0, 0, 32'h108, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
